// File: rtl/multi_fifo_pkg.sv
// Shared definitions for the latency-insensitive FIFO: token handshake helper
// and parameter defaults.
package multi_fifo_pkg;

    localparam int default_width = 8;
    localparam int default_depth = 4;
    localparam int default_logd  = 2;

    // An absent input token is trivially "consumed"; a present one only on fire.
    function automatic logic in_consumed(input logic valid, input logic fire);
        return valid ? fire : 1'b1;
    endfunction

endpackage

// File: rtl/multi_fifo_out_token_tracker.sv
// Tracks whether one output token has been taken during the current model step.
module out_token_tracker (
    input  logic CLK,
    input  logic RST_N,
    input  logic CONSUMED,
    input  logic fire,
    output logic VALID,
    output logic outDone
);

    logic done;

    assign outDone = done || CONSUMED;
    assign VALID   = !done;

    // Latch completion until the step fires; repeated CONSUMED while done is harmless.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            done <= 1'b0;
        end else if (fire) begin
            done <= 1'b0;
        end else begin
            done <= outDone;
        end
    end

endmodule

// File: rtl/multi_fifo.sv
// Latency-insensitive FIFO: advances one model step per fire, consuming one token
// on each input channel and producing one token on each output channel.
module multi_fifo
    import multi_fifo_pkg::*;
#(
    parameter int width = default_width,
    parameter int depth = default_depth,
    parameter int logd  = default_logd
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [width-1:0] IN_ENQ,
    input  logic             IN_ENQ_VALID,
    output logic             IN_ENQ_CONSUMED,
    input  logic             IN_EN_ENQ,
    input  logic             IN_EN_ENQ_VALID,
    output logic             IN_EN_ENQ_CONSUMED,
    input  logic             IN_EN_DEQ,
    input  logic             IN_EN_DEQ_VALID,
    output logic             IN_EN_DEQ_CONSUMED,
    output logic [width-1:0] OUT_FIRST,
    output logic             OUT_FIRST_VALID,
    input  logic             OUT_FIRST_CONSUMED,
    output logic             OUT_NOT_EMPTY,
    output logic             OUT_NOT_EMPTY_VALID,
    input  logic             OUT_NOT_EMPTY_CONSUMED,
    output logic             OUT_NOT_FULL,
    output logic             OUT_NOT_FULL_VALID,
    input  logic             OUT_NOT_FULL_CONSUMED
);

    localparam int count_w = logd + 1;

    logic [width-1:0]   storage [depth];
    logic [logd-1:0]    head;
    logic [logd-1:0]    tail;
    logic [count_w-1:0] count;

    logic all_in;
    logic all_out;
    logic fire;
    logic done_first_out;
    logic done_ne_out;
    logic done_nf_out;
    logic is_empty;
    logic is_full;
    logic do_enq;
    logic do_deq;

    assign is_empty = (count == '0);
    assign is_full  = (count == count_w'(depth));

    assign OUT_FIRST     = storage[head];
    assign OUT_NOT_EMPTY = !is_empty;
    assign OUT_NOT_FULL  = !is_full;

    assign all_in  = IN_ENQ_VALID && IN_EN_ENQ_VALID && IN_EN_DEQ_VALID;
    assign all_out = done_first_out && done_ne_out && done_nf_out;
    assign fire    = all_in && all_out;

    assign IN_ENQ_CONSUMED    = in_consumed(IN_ENQ_VALID, fire);
    assign IN_EN_ENQ_CONSUMED = in_consumed(IN_EN_ENQ_VALID, fire);
    assign IN_EN_DEQ_CONSUMED = in_consumed(IN_EN_DEQ_VALID, fire);

    // A full FIFO drops the enqueue even when a dequeue frees a slot this step.
    assign do_enq = IN_EN_ENQ && !is_full;
    assign do_deq = IN_EN_DEQ && !is_empty;

    out_token_tracker u_first (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CONSUMED (OUT_FIRST_CONSUMED),
        .fire     (fire),
        .VALID    (OUT_FIRST_VALID),
        .outDone  (done_first_out)
    );

    out_token_tracker u_not_empty (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CONSUMED (OUT_NOT_EMPTY_CONSUMED),
        .fire     (fire),
        .VALID    (OUT_NOT_EMPTY_VALID),
        .outDone  (done_ne_out)
    );

    out_token_tracker u_not_full (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CONSUMED (OUT_NOT_FULL_CONSUMED),
        .fire     (fire),
        .VALID    (OUT_NOT_FULL_VALID),
        .outDone  (done_nf_out)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (fire) begin
            if (do_enq) begin
                tail <= tail + 1'b1;
            end
            if (do_deq) begin
                head <= head + 1'b1;
            end
            count <= count + count_w'(do_enq) - count_w'(do_deq);
        end
    end

    // Storage carries no reset; its content is meaningless while count is zero.
    always_ff @(posedge CLK) begin
        if (RST_N && fire && do_enq) begin
            storage[tail] <= IN_ENQ;
        end
    end

endmodule

// File: tb/tb_multi_fifo.sv
// Self-checking bench for multi_fifo: directed vector table, hand sequences for
// multi-cycle corners, and randomized handshakes against a queue-based model.
module tb_multi_fifo;

    localparam int width = 8;
    localparam int depth = 4;
    localparam int logd  = 2;

    typedef struct {
        logic [7:0] enq;
        logic       enq_v;
        logic       en_enq;
        logic       en_enq_v;
        logic       en_deq;
        logic       en_deq_v;
        logic       c_first;
        logic       c_ne;
        logic       c_nf;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic       chk_first;
        logic [7:0] exp_first;
        logic       exp_ne;
        logic       exp_nf;
        logic       exp_fire;
    } vec_t;

    logic             CLK;
    logic             RST_N;
    logic [width-1:0] IN_ENQ;
    logic             IN_ENQ_VALID;
    logic             IN_ENQ_CONSUMED;
    logic             IN_EN_ENQ;
    logic             IN_EN_ENQ_VALID;
    logic             IN_EN_ENQ_CONSUMED;
    logic             IN_EN_DEQ;
    logic             IN_EN_DEQ_VALID;
    logic             IN_EN_DEQ_CONSUMED;
    logic [width-1:0] OUT_FIRST;
    logic             OUT_FIRST_VALID;
    logic             OUT_FIRST_CONSUMED;
    logic             OUT_NOT_EMPTY;
    logic             OUT_NOT_EMPTY_VALID;
    logic             OUT_NOT_EMPTY_CONSUMED;
    logic             OUT_NOT_FULL;
    logic             OUT_NOT_FULL_VALID;
    logic             OUT_NOT_FULL_CONSUMED;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the FIFO as a queue plus one "already taken" flag per output.
    logic [7:0] model_q[$];
    logic       m_done_first = 1'b0;
    logic       m_done_ne    = 1'b0;
    logic       m_done_nf    = 1'b0;

    multi_fifo #(.width(width), .depth(depth), .logd(logd)) dut (
        .CLK                    (CLK),
        .RST_N                  (RST_N),
        .IN_ENQ                 (IN_ENQ),
        .IN_ENQ_VALID           (IN_ENQ_VALID),
        .IN_ENQ_CONSUMED        (IN_ENQ_CONSUMED),
        .IN_EN_ENQ              (IN_EN_ENQ),
        .IN_EN_ENQ_VALID        (IN_EN_ENQ_VALID),
        .IN_EN_ENQ_CONSUMED     (IN_EN_ENQ_CONSUMED),
        .IN_EN_DEQ              (IN_EN_DEQ),
        .IN_EN_DEQ_VALID        (IN_EN_DEQ_VALID),
        .IN_EN_DEQ_CONSUMED     (IN_EN_DEQ_CONSUMED),
        .OUT_FIRST              (OUT_FIRST),
        .OUT_FIRST_VALID        (OUT_FIRST_VALID),
        .OUT_FIRST_CONSUMED     (OUT_FIRST_CONSUMED),
        .OUT_NOT_EMPTY          (OUT_NOT_EMPTY),
        .OUT_NOT_EMPTY_VALID    (OUT_NOT_EMPTY_VALID),
        .OUT_NOT_EMPTY_CONSUMED (OUT_NOT_EMPTY_CONSUMED),
        .OUT_NOT_FULL           (OUT_NOT_FULL),
        .OUT_NOT_FULL_VALID     (OUT_NOT_FULL_VALID),
        .OUT_NOT_FULL_CONSUMED  (OUT_NOT_FULL_CONSUMED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic stim_t mk(input logic [7:0] enq, input logic en_enq, input logic en_deq,
                                 input logic all_v, input logic c_first, input logic c_ne, input logic c_nf);
        stim_t s;
        s.enq      = enq;
        s.enq_v    = all_v;
        s.en_enq   = en_enq;
        s.en_enq_v = all_v;
        s.en_deq   = en_deq;
        s.en_deq_v = all_v;
        s.c_first  = c_first;
        s.c_ne     = c_ne;
        s.c_nf     = c_nf;
        return s;
    endfunction

    // Drives one cycle from the negedge, checks every output against the model
    // before the posedge, then advances the model across the posedge.
    task automatic apply_stimulus(input stim_t s, output logic fired);
        logic model_fire;
        logic enq_ok;
        logic deq_ok;
        IN_ENQ                 = s.enq;
        IN_ENQ_VALID           = s.enq_v;
        IN_EN_ENQ              = s.en_enq;
        IN_EN_ENQ_VALID        = s.en_enq_v;
        IN_EN_DEQ              = s.en_deq;
        IN_EN_DEQ_VALID        = s.en_deq_v;
        OUT_FIRST_CONSUMED     = s.c_first;
        OUT_NOT_EMPTY_CONSUMED = s.c_ne;
        OUT_NOT_FULL_CONSUMED  = s.c_nf;
        #1;
        model_fire = s.enq_v && s.en_enq_v && s.en_deq_v && (m_done_first || s.c_first)
                     && (m_done_ne || s.c_ne) && (m_done_nf || s.c_nf) && RST_N;
        check_output("first_valid", 8'(OUT_FIRST_VALID), 8'(!m_done_first));
        check_output("ne_valid", 8'(OUT_NOT_EMPTY_VALID), 8'(!m_done_ne));
        check_output("nf_valid", 8'(OUT_NOT_FULL_VALID), 8'(!m_done_nf));
        check_output("not_empty", 8'(OUT_NOT_EMPTY), 8'(model_q.size() != 0));
        check_output("not_full", 8'(OUT_NOT_FULL), 8'(model_q.size() != depth));
        if (model_q.size() != 0) begin
            check_output("first", OUT_FIRST, model_q[0]);
        end
        if (RST_N) begin
            check_output("enq_consumed", 8'(IN_ENQ_CONSUMED), 8'(s.enq_v ? model_fire : 1'b1));
            check_output("en_enq_consumed", 8'(IN_EN_ENQ_CONSUMED), 8'(s.en_enq_v ? model_fire : 1'b1));
            check_output("en_deq_consumed", 8'(IN_EN_DEQ_CONSUMED), 8'(s.en_deq_v ? model_fire : 1'b1));
        end
        fired = model_fire;
        @(posedge CLK);
        if (!RST_N) begin
            model_q.delete();
            m_done_first = 1'b0;
            m_done_ne    = 1'b0;
            m_done_nf    = 1'b0;
        end else if (model_fire) begin
            enq_ok = s.en_enq && (model_q.size() != depth);
            deq_ok = s.en_deq && (model_q.size() != 0);
            if (deq_ok) void'(model_q.pop_front());
            if (enq_ok) model_q.push_back(s.enq);
            m_done_first = 1'b0;
            m_done_ne    = 1'b0;
            m_done_nf    = 1'b0;
        end else begin
            m_done_first = m_done_first || s.c_first;
            m_done_ne    = m_done_ne || s.c_ne;
            m_done_nf    = m_done_nf || s.c_nf;
        end
        @(negedge CLK);
    endtask

    initial begin
        vec_t  table_v[11];
        stim_t s;
        logic  fired;
        logic  fire_hist[6];

        RST_N = 1'b0;
        s = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        IN_ENQ = 8'h00; IN_ENQ_VALID = 1'b0; IN_EN_ENQ = 1'b0; IN_EN_ENQ_VALID = 1'b0;
        IN_EN_DEQ = 1'b0; IN_EN_DEQ_VALID = 1'b0; OUT_FIRST_CONSUMED = 1'b0;
        OUT_NOT_EMPTY_CONSUMED = 1'b0; OUT_NOT_FULL_CONSUMED = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Reset state and idle: nothing valid means no fire and every input acked.
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output("rst_first_valid", 8'(OUT_FIRST_VALID), 8'h01);
            check_output("rst_not_empty", 8'(OUT_NOT_EMPTY), 8'h00);
            check_output("rst_not_full", 8'(OUT_NOT_FULL), 8'h01);
            check_output("idle_enq_ack", 8'(IN_ENQ_CONSUMED), 8'h01);
            @(negedge CLK);
        end
        apply_stimulus(mk(8'h77, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1), fired);

        // After the idle consume above all outputs are done; one step still pending.
        s = mk(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(s, fired);
        check_output("pending_step_fire", 8'(fired), 8'h01);

        table_v[0]  = '{mk(8'h11, 1, 0, 1, 1, 1, 1), 0, 8'h00, 0, 1, 1};
        table_v[1]  = '{mk(8'h22, 1, 0, 1, 1, 1, 1), 1, 8'h11, 1, 1, 1};
        table_v[2]  = '{mk(8'h33, 1, 0, 1, 1, 1, 1), 1, 8'h11, 1, 1, 1};
        table_v[3]  = '{mk(8'h44, 1, 0, 1, 1, 1, 1), 1, 8'h11, 1, 1, 1};
        table_v[4]  = '{mk(8'h55, 1, 0, 1, 1, 1, 1), 1, 8'h11, 1, 0, 1};
        table_v[5]  = '{mk(8'h66, 1, 1, 1, 1, 1, 1), 1, 8'h11, 1, 0, 1};
        table_v[6]  = '{mk(8'h00, 0, 0, 1, 1, 1, 1), 1, 8'h22, 1, 1, 1};
        table_v[7]  = '{mk(8'h00, 0, 1, 1, 1, 1, 1), 1, 8'h22, 1, 1, 1};
        table_v[8]  = '{mk(8'h00, 0, 1, 1, 1, 1, 1), 1, 8'h33, 1, 1, 1};
        table_v[9]  = '{mk(8'h00, 0, 1, 1, 1, 1, 1), 1, 8'h44, 1, 1, 1};
        table_v[10] = '{mk(8'h00, 0, 1, 1, 1, 1, 1), 0, 8'h00, 0, 1, 1};
        for (int i = 0; i < 11; i++) begin
            IN_ENQ = table_v[i].s.enq;
            IN_ENQ_VALID = table_v[i].s.enq_v;
            IN_EN_ENQ = table_v[i].s.en_enq;
            IN_EN_ENQ_VALID = table_v[i].s.en_enq_v;
            IN_EN_DEQ = table_v[i].s.en_deq;
            IN_EN_DEQ_VALID = table_v[i].s.en_deq_v;
            OUT_FIRST_CONSUMED = table_v[i].s.c_first;
            OUT_NOT_EMPTY_CONSUMED = table_v[i].s.c_ne;
            OUT_NOT_FULL_CONSUMED = table_v[i].s.c_nf;
            #1;
            if (table_v[i].chk_first) check_output($sformatf("tbl%0d_first", i), OUT_FIRST, table_v[i].exp_first);
            check_output($sformatf("tbl%0d_ne", i), 8'(OUT_NOT_EMPTY), 8'(table_v[i].exp_ne));
            check_output($sformatf("tbl%0d_nf", i), 8'(OUT_NOT_FULL), 8'(table_v[i].exp_nf));
            check_output($sformatf("tbl%0d_fire", i), 8'(IN_ENQ_CONSUMED), 8'(table_v[i].exp_fire));
            apply_stimulus(table_v[i].s, fired);
        end

        // Staggered consumption from empty: outputs taken at cycles 1, 3 and 5.
        for (int c = 0; c < 6; c++) begin
            s = mk(8'hA5, 1'b1, 1'b0, 1'b1, c >= 1, c >= 3, c >= 5);
            #1;
            check_output($sformatf("stag%0d_first_valid", c), 8'(OUT_FIRST_VALID), 8'(c < 2));
            apply_stimulus(s, fired);
            fire_hist[c] = fired;
        end
        for (int c = 0; c < 6; c++) begin
            check_output($sformatf("stag%0d_fire", c), 8'(fire_hist[c]), 8'(c == 5));
        end

        // Bring count to 2, then ten simultaneous enq/deq steps through the wrap.
        apply_stimulus(mk(8'hB6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1), fired);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp_head;
            exp_head = (i == 0) ? 8'hA5 : (i == 1) ? 8'hB6 : 8'(i - 1);
            #1;
            check_output($sformatf("wrap%0d_head", i), OUT_FIRST, exp_head);
            apply_stimulus(mk(8'(i + 1), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1), fired);
        end
        check_output("wrap_count", 8'(model_q.size()), 8'd2);

        // Partially consumed step, then reset mid-step.
        apply_stimulus(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), fired);
        RST_N = 1'b0;
        apply_stimulus(mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), fired);
        RST_N = 1'b1;
        #1;
        check_output("post_rst_first_valid", 8'(OUT_FIRST_VALID), 8'h01);
        check_output("post_rst_not_empty", 8'(OUT_NOT_EMPTY), 8'h00);
        check_output("post_rst_not_full", 8'(OUT_NOT_FULL), 8'h01);

        // Randomized handshakes against the queue model.
        for (int i = 0; i < 400; i++) begin
            s.enq      = 8'($urandom);
            s.enq_v    = ($urandom_range(0, 3) != 0);
            s.en_enq   = ($urandom_range(0, 2) != 0);
            s.en_enq_v = ($urandom_range(0, 3) != 0);
            s.en_deq   = ($urandom_range(0, 1) != 0);
            s.en_deq_v = ($urandom_range(0, 3) != 0);
            s.c_first  = ($urandom_range(0, 2) != 0);
            s.c_ne     = ($urandom_range(0, 2) != 0);
            s.c_nf     = ($urandom_range(0, 2) != 0);
            apply_stimulus(s, fired);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
